// File: rtl/tm_pio_master_pkg.sv
// -----------------------------------------------------------------------------
// tm_pio_master_pkg
// Shared constants and types for the traffic-manager PIO initiator.
//   PIO_W            : width of PIO address/data paths (32)
//   SEL_NBITS        : width of the target-select field in the address (4)
//   ERR_DATA_DEFAULT : read data returned on a bad target or timeout
//   pio_state_e      : FSM state encoding (IDLE, ISSUE, WAIT, DONE)
//   sel_onehot()     : expands a 4-bit target index to a 16-bit one-hot mask
// -----------------------------------------------------------------------------
package tm_pio_master_pkg;

    localparam int          PIO_W            = 32;
    localparam int          SEL_NBITS        = 4;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_DEAD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } pio_state_e;

    function automatic logic [15:0] sel_onehot(input logic [SEL_NBITS-1:0] sel);
        sel_onehot = 16'd1 << sel;
    endfunction

endpackage

// File: rtl/tm_pio_ack_mux.sv
// -----------------------------------------------------------------------------
// tm_pio_ack_mux
// Combinational selector picking the acknowledge and read data of the target
// addressed by sel.
//   sel       in  4          : target index
//   tgt_ack   in  N_TGT      : per-target acknowledge
//   tgt_rdata in  N_TGT*32   : per-target read data, target 0 in the LSBs
//   ack       out 1          : tgt_ack[sel] (0 when sel >= N_TGT)
//   rdata     out 32         : tgt_rdata slice of sel (0 when sel >= N_TGT)
// -----------------------------------------------------------------------------
module tm_pio_ack_mux
    import tm_pio_master_pkg::*;
#(
    parameter int N_TGT = 4
) (
    input  logic [SEL_NBITS-1:0] sel,
    input  logic [N_TGT-1:0]     tgt_ack,
    input  logic [N_TGT*32-1:0]  tgt_rdata,
    output logic                 ack,
    output logic [31:0]          rdata
);

    // Zero-padded to the full 16-target space so any 4-bit sel indexes a real
    // bit; absent targets read back as no-ack / zero data.
    logic [15:0]  ack_pad_s;
    logic [511:0] rdata_pad_s;

    assign ack_pad_s   = 16'(tgt_ack);
    assign rdata_pad_s = 512'(tgt_rdata);

    assign ack   = ack_pad_s[sel];
    assign rdata = rdata_pad_s[{sel, 5'd0} +: 32];

endmodule

// File: rtl/tm_pio_master.sv
// -----------------------------------------------------------------------------
// tm_pio_master
// PIO initiator for the traffic-manager register space. Accepts one host
// command at a time, decodes the target from pio_addr[SEL_LSB+3:SEL_LSB],
// drives the reg_* bus to that target and returns its data or an error.
//   clk, rst_n          : core clock, asynchronous active-low reset
//   pio_req/rnw/addr/wdata in : host command (req is a single-cycle pulse)
//   pio_busy  out       : command in flight
//   pio_done  out       : one-cycle completion pulse
//   pio_err   out       : bad target or timeout, valid with pio_done
//   pio_rdata out       : read data (ERR_DATA on error), valid with pio_done
//   reg_ms    out N_TGT : one-hot target select
//   reg_rd/reg_wr out   : single-cycle access strobes
//   reg_addr/reg_din out: address and write data to the targets
//   tgt_ack   in  N_TGT : per-target acknowledge
//   tgt_rdata in  N_TGT*32 : per-target read data, target 0 in the LSBs
// -----------------------------------------------------------------------------
module tm_pio_master
    import tm_pio_master_pkg::*;
#(
    parameter int          N_TGT    = 4,
    parameter int          SEL_LSB  = 20,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pio_req,
    input  logic                pio_rnw,
    input  logic [31:0]         pio_addr,
    input  logic [31:0]         pio_wdata,
    output logic                pio_busy,
    output logic                pio_done,
    output logic                pio_err,
    output logic [31:0]         pio_rdata,
    output logic [N_TGT-1:0]    reg_ms,
    output logic                reg_rd,
    output logic                reg_wr,
    output logic [31:0]         reg_addr,
    output logic [31:0]         reg_din,
    input  logic [N_TGT-1:0]    tgt_ack,
    input  logic [N_TGT*32-1:0] tgt_rdata
);

    pio_state_e           state_r;
    logic [SEL_NBITS-1:0] sel_r;
    logic                 rnw_r;
    logic [7:0]           cnt_r;

    logic [SEL_NBITS-1:0] req_sel_s;
    logic                 req_bad_s;
    logic [15:0]          req_onehot_s;
    logic                 ack_s;
    logic [31:0]          ack_rdata_s;

    assign req_sel_s    = pio_addr[SEL_LSB +: SEL_NBITS];
    assign req_bad_s    = (32'(req_sel_s) >= N_TGT);
    assign req_onehot_s = sel_onehot(req_sel_s);

    // Only the acknowledge of the latched target is ever seen by the FSM.
    tm_pio_ack_mux #(
        .N_TGT (N_TGT)
    ) u_ack_mux (
        .sel       (sel_r),
        .tgt_ack   (tgt_ack),
        .tgt_rdata (tgt_rdata),
        .ack       (ack_s),
        .rdata     (ack_rdata_s)
    );

    // Command FSM, timeout counter, capture registers and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            sel_r     <= 4'd0;
            rnw_r     <= 1'b0;
            cnt_r     <= 8'd0;
            pio_busy  <= 1'b0;
            pio_done  <= 1'b0;
            pio_err   <= 1'b0;
            pio_rdata <= 32'd0;
            reg_ms    <= '0;
            reg_rd    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= 32'd0;
            reg_din   <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pio_req) begin
                        rnw_r    <= pio_rnw;
                        sel_r    <= req_sel_s;
                        pio_busy <= 1'b1;
                        if (req_bad_s) begin
                            // Bad target: no bus activity at all.
                            state_r <= ST_DONE;
                        end else begin
                            reg_addr <= pio_addr;
                            reg_din  <= pio_wdata;
                            reg_ms   <= req_onehot_s[N_TGT-1:0];
                            reg_rd   <= pio_rnw;
                            reg_wr   <= ~pio_rnw;
                            state_r  <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    reg_rd  <= 1'b0;
                    reg_wr  <= 1'b0;
                    cnt_r   <= 8'd0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Ack is tested first so it wins over a coincident expiry.
                    if (ack_s) begin
                        pio_done  <= 1'b1;
                        pio_err   <= 1'b0;
                        pio_rdata <= rnw_r ? ack_rdata_s : 32'd0;
                        reg_ms    <= '0;
                        state_r   <= ST_DONE;
                    end else if (cnt_r == 8'(TIMEOUT)) begin
                        pio_done  <= 1'b1;
                        pio_err   <= 1'b1;
                        pio_rdata <= ERR_DATA;
                        reg_ms    <= '0;
                        state_r   <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    if (pio_done) begin
                        pio_done  <= 1'b0;
                        pio_err   <= 1'b0;
                        pio_rdata <= 32'd0;
                        pio_busy  <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        // Entered straight from IDLE on a bad target: publish
                        // the error response one cycle later, so it lands on
                        // cycle 2 after the request.
                        pio_done  <= 1'b1;
                        pio_err   <= 1'b1;
                        pio_rdata <= ERR_DATA;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tm_pio_master.sv
module tb_tm_pio_master;

    localparam int TMO = 255;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pio_req;
    logic         pio_rnw;
    logic [31:0]  pio_addr;
    logic [31:0]  pio_wdata;
    logic         pio_busy;
    logic         pio_done;
    logic         pio_err;
    logic [31:0]  pio_rdata;
    logic [3:0]   reg_ms;
    logic         reg_rd;
    logic         reg_wr;
    logic [31:0]  reg_addr;
    logic [31:0]  reg_din;
    logic [3:0]   tgt_ack;
    logic [127:0] tgt_rdata;

    int n_checks = 0;
    int n_err    = 0;

    tm_pio_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pio_req   (pio_req),
        .pio_rnw   (pio_rnw),
        .pio_addr  (pio_addr),
        .pio_wdata (pio_wdata),
        .pio_busy  (pio_busy),
        .pio_done  (pio_done),
        .pio_err   (pio_err),
        .pio_rdata (pio_rdata),
        .reg_ms    (reg_ms),
        .reg_rd    (reg_rd),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_din   (reg_din),
        .tgt_ack   (tgt_ack),
        .tgt_rdata (tgt_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ms"},    32'(reg_ms), 32'd0);
        check({tag, "_strb"},  32'({reg_rd, reg_wr}), 32'd0);
        check({tag, "_addr"},  reg_addr, 32'd0);
        check({tag, "_din"},   reg_din, 32'd0);
        check({tag, "_flags"}, 32'({pio_busy, pio_done, pio_err}), 32'd0);
        check({tag, "_rdata"}, pio_rdata, 32'd0);
    endtask

    // One host command plus a simple responder. ack_k: WAIT cycle in which the
    // target acks (first WAIT cycle = 0), negative = never. Expected results
    // come from the command-level timing rules, not from the DUT.
    task automatic run_cmd(input string tag, input logic rnw, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_k,
                           input logic [31:0] ack_data, input logic spur, input logic b2b);
        int          sel;
        logic        good;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_ms;
        int          done_cyc = -1;
        int          n_rd = 0, n_wr = 0, strobe_cyc = -1;
        int          ms_bad = 0, busy_bad = 0, extra = 0;
        logic [31:0] addr_at = 32'd0, din_at = 32'd0;
        logic        err_at = 1'b0;
        logic [31:0] rdata_at = 32'd0;
        int          other;

        sel  = int'(addr[23:20]);
        good = (sel < 4);
        if (!good) begin
            exp_lat = 2;  exp_err = 1'b1; exp_rdata = 32'hDEAD_DEAD;
        end else if (ack_k >= 0 && ack_k <= TMO) begin
            exp_lat = 3 + ack_k; exp_err = 1'b0; exp_rdata = rnw ? ack_data : 32'd0;
        end else begin
            exp_lat = TMO + 3; exp_err = 1'b1; exp_rdata = 32'hDEAD_DEAD;
        end
        exp_ms = good ? 4'(1 << sel) : 4'd0;
        other  = (sel == 3) ? 0 : 3;

        for (int i = 0; i < 4; i++) tgt_rdata[i*32 +: 32] = $urandom;
        if (good) tgt_rdata[sel*32 +: 32] = ack_data;

        @(posedge clk); #1;
        pio_req = 1'b1; pio_rnw = rnw; pio_addr = addr; pio_wdata = wdata;

        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(posedge clk); #1;
            if (reg_rd) n_rd++;
            if (reg_wr) n_wr++;
            if (reg_rd || reg_wr) begin
                strobe_cyc = cyc; addr_at = reg_addr; din_at = reg_din;
            end
            if (reg_ms !== (pio_done ? 4'd0 : exp_ms)) ms_bad++;
            if (pio_busy !== 1'b1) busy_bad++;
            if (pio_done === 1'b1) begin
                done_cyc = cyc; err_at = pio_err; rdata_at = pio_rdata;
                break;
            end
            pio_req = 1'b0;
            tgt_ack = 4'd0;
            if (good && ack_k >= 0 && cyc == 2 + ack_k) tgt_ack[sel] = 1'b1;
            if (spur && cyc == 3) tgt_ack[other] = 1'b1;
            if (spur && cyc == 2) begin
                pio_req = 1'b1; pio_rnw = $urandom_range(0, 1) == 1;
                pio_addr = $urandom & 32'hFF0F_FFFF;
            end
        end
        pio_req = 1'b0;
        tgt_ack = 4'd0;

        check({tag, "_latency"}, 32'(done_cyc), 32'(exp_lat));
        check({tag, "_err"},     32'(err_at), 32'(exp_err));
        check({tag, "_rdata"},   rdata_at, exp_rdata);
        check({tag, "_strobes"}, 32'(n_rd * 2 + n_wr), good ? (rnw ? 32'd2 : 32'd1) : 32'd0);
        check({tag, "_ms_bad"},  32'(ms_bad), 32'd0);
        check({tag, "_busy_bad"}, 32'(busy_bad), 32'd0);
        if (good) begin
            check({tag, "_strobe_cyc"}, 32'(strobe_cyc), 32'd1);
            check({tag, "_addr"},       addr_at, addr);
            check({tag, "_din"},        din_at, wdata);
        end
        if (!b2b) begin
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                if (pio_done !== 1'b0 || pio_busy !== 1'b0) extra++;
            end
            check({tag, "_post_idle"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int n_late_done;
        int sel;
        logic [31:0] a;

        rst_n = 1'b0; pio_req = 1'b0; pio_rnw = 1'b0; pio_addr = 32'd0;
        pio_wdata = 32'd0; tgt_ack = 4'd0; tgt_rdata = 128'd0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        run_cmd("rd_t2", 1'b1, 32'h0020_0010, $urandom, 2, 32'h1234_5678, 1'b0, 1'b0);
        run_cmd("wr_t0", 1'b0, 32'h0000_0008, 32'hCAFE_F00D, 0, $urandom, 1'b0, 1'b0);
        run_cmd("bad_sel5", 1'b1, 32'h0050_0000, 32'd0, 0, 32'd0, 1'b0, 1'b0);
        run_cmd("timeout_t1", 1'b1, 32'h0010_0000, 32'd0, -1, 32'd0, 1'b0, 1'b0);
        run_cmd("ack_at_expiry", 1'b1, 32'h0010_0004, 32'd0, TMO, 32'h0BAD_F00D, 1'b0, 1'b0);
        run_cmd("spur_t1", 1'b1, 32'h0010_0020, 32'd0, 4, 32'hA5A5_0001, 1'b1, 1'b0);
        run_cmd("b2b_first", 1'b0, 32'h0030_0100, 32'h1111_2222, 1, 32'd0, 1'b0, 1'b1);
        run_cmd("b2b_second", 1'b1, 32'h0030_0104, 32'd0, 0, 32'h3333_4444, 1'b0, 1'b0);

        // Reset in the middle of WAIT, then a late ack from the abandoned target.
        @(posedge clk); #1;
        pio_req = 1'b1; pio_rnw = 1'b1; pio_addr = 32'h0010_0040;
        @(posedge clk); #1;
        pio_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midwait_busy", 32'(pio_busy), 32'd1);
        check("midwait_ms", 32'(reg_ms), 32'h2);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tgt_ack = 4'b0010;
        n_late_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 3) tgt_ack = 4'd0;
            if (pio_done !== 1'b0 || pio_busy !== 1'b0 || reg_ms !== 4'd0) n_late_done++;
        end
        check("late_ack_ignored", 32'(n_late_done), 32'd0);
        run_cmd("after_rst", 1'b1, 32'h0010_0044, 32'd0, 3, 32'h7777_0001, 1'b0, 1'b0);

        // Randomised commands, including bad selects and spurious traffic.
        for (int t = 0; t < 16; t++) begin
            sel = (t % 5 == 4) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
            a = $urandom;
            a[23:20] = 4'(sel);
            run_cmd($sformatf("rnd%0d", t), $urandom_range(0, 1) == 1, a, $urandom,
                    int'($urandom_range(0, 12)), $urandom,
                    (sel < 4) && ($urandom_range(0, 1) == 1), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
